pixel_bus_sink: RTL and testbench

PIXEL_BUS_SINK -- requirements
Module: pixel_bus_sink

---
 rtl/pixel_bus_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 66 ++++++
 rtl/pixel_bus_sink.sv | 209 ++++++++++++++++++++
 tb/tb_pixel_bus_sink.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_pkg.sv
// Shared definitions for the pixel bus sink: screen geometry defaults,
// framebuffer word widths, FSM state encoding and colour conversion.
package pixel_bus_pkg;

    localparam int SCREEN_W_DEF   = 160;
    localparam int SCREEN_H_DEF   = 120;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 9;
    localparam int ENTRY_W  = ADDR_W + COLOUR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // Keep the top three bits of each 8-bit channel: {R[23:21],G[15:13],B[7:5]}.
    function automatic logic [COLOUR_W-1:0] rgb24_to_rgb9(input logic [23:0] rgb);
        return {rgb[23:21], rgb[15:13], rgb[7:5]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding captured {address, colour} pixel entries.
// A push into a full FIFO is accepted only when a pop completes in the
// same cycle; the head entry is presented combinationally on o_data.
module pixel_fifo
    import pixel_bus_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        w_pop_ok  = i_pop && !w_empty;
        w_push_ok = i_push && (!w_full || w_pop_ok);
        o_full    = w_full;
        o_empty   = w_empty;
        o_count   = r_wr_ptr - r_rd_ptr;
        o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];
    end

    // Advance read/write pointers on accepted pop/push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only observed through the valid head.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pixel_bus_sink.sv
// Pixel bus sink: captures pixels from the shared draw bus, buffers them,
// and writes them into a linear framebuffer; also performs full-screen
// clears on request. Bus pixels arriving during a clear are buffered and
// written once the clear completes.
module pixel_bus_sink
    import pixel_bus_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 vga_draw_enable_bus,
    input  logic [7:0]           vga_x_out_bus,
    input  logic [7:0]           vga_y_out_bus,
    input  logic [23:0]          vga_RGB_out_bus,
    input  logic                 clear,
    input  logic [8:0]           clear_colour,
    input  logic                 fb_ready,
    output logic                 fb_write,
    output logic [14:0]          fb_address,
    output logic [8:0]           fb_colour,
    output logic                 busy,
    output logic                 overflow,
    output logic                 clear_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_clear_pend;
    logic [ADDR_W-1:0]      r_clear_cnt;
    logic [COLOUR_W-1:0]    r_clear_colour;
    logic                   r_overflow;
    logic                   r_clear_done;

    logic                   w_in_range;
    logic                   w_capture;
    logic [ADDR_W-1:0]      w_pix_addr;
    logic [ENTRY_W-1:0]     w_push_data;
    logic [ENTRY_W-1:0]     w_fifo_data;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_last;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_enter_clear;
    logic                   w_clear_adv;
    logic                   w_clear_last;

    // Capture qualification, address arithmetic and colour packing.
    // Only a strobe of exactly 1 counts; unknown values fall to "no pixel".
    always_comb begin
        w_in_range  = (32'(vga_x_out_bus) < 32'(SCREEN_W)) &&
                      (32'(vga_y_out_bus) < 32'(SCREEN_H));
        w_capture   = 1'b0;
        if (vga_draw_enable_bus == 1'b1) begin
            w_capture = w_in_range;
        end else begin
            w_capture = 1'b0;
        end
        w_pix_addr  = ADDR_W'(vga_y_out_bus) * ADDR_W'(SCREEN_W) + ADDR_W'(vga_x_out_bus);
        w_push_data = {w_pix_addr, rgb24_to_rgb9(vga_RGB_out_bus)};
        w_fifo_last = (w_fifo_count == CNT_W'(1));
        w_drop      = w_capture && w_fifo_full && !w_pop;
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-state control strobes. A pixel captured while
    // idle moves straight to S_DRAIN so it is written in the very next cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_enter_clear = 1'b0;
        w_clear_adv   = 1'b0;
        w_clear_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_clear_pend && w_fifo_empty) begin
                    w_state_nxt   = S_CLEAR;
                    w_enter_clear = 1'b1;
                end else if (!w_fifo_empty || w_capture) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (fb_ready) begin
                    w_pop = 1'b1;
                    if (w_fifo_last && !w_capture) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_CLEAR: begin
                if (fb_ready) begin
                    w_clear_adv = 1'b1;
                    if (r_clear_cnt == LAST_ADDR) begin
                        w_clear_last = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end else begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear bookkeeping: pending flag, fill colour, address counter, done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clear_pend   <= 1'b0;
            r_clear_cnt    <= '0;
            r_clear_colour <= '0;
            r_clear_done   <= 1'b0;
        end else begin
            r_clear_done <= w_clear_last;
            if (w_enter_clear) begin
                r_clear_pend   <= 1'b0;
                r_clear_cnt    <= '0;
                r_clear_colour <= clear_colour;
            end else begin
                if (clear == 1'b1 && r_state != S_CLEAR) begin
                    r_clear_pend <= 1'b1;
                end
                if (w_clear_adv) begin
                    r_clear_cnt <= r_clear_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Sticky overflow flag; only a new clear (or reset) wipes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_enter_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Framebuffer port and status outputs, decoded from registered state.
    always_comb begin
        fb_write   = 1'b0;
        fb_address = '0;
        fb_colour  = '0;
        case (r_state)
            S_DRAIN: begin
                fb_write   = 1'b1;
                fb_address = w_fifo_data[ENTRY_W-1:COLOUR_W];
                fb_colour  = w_fifo_data[COLOUR_W-1:0];
            end
            S_CLEAR: begin
                fb_write   = 1'b1;
                fb_address = r_clear_cnt;
                fb_colour  = r_clear_colour;
            end
            default: begin
                fb_write   = 1'b0;
                fb_address = '0;
                fb_colour  = '0;
            end
        endcase
        busy       = !w_fifo_empty || r_clear_pend || (r_state == S_CLEAR);
        overflow   = r_overflow;
        clear_done = r_clear_done;
    end

endmodule

// File: tb/tb_pixel_bus_sink.sv
// Directed self-checking bench for pixel_bus_sink.
module tb_pixel_bus_sink;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
    logic        clear;
    logic [8:0]  clear_colour;
    logic        fb_ready;
    logic        fb_write;
    logic [14:0] fb_address;
    logic [8:0]  fb_colour;
    logic        busy;
    logic        overflow;
    logic        clear_done;

    int checks;
    int failures;

    // B[7:5] walks 0..5 so the packed colour equals the index.
    logic [23:0] rgb_tab [6] = '{24'h000000, 24'h000020, 24'h000040,
                                 24'h000060, 24'h000080, 24'h0000A0};
    logic [8:0]  col_tab [6] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005};

    pixel_bus_sink dut (
        .clk                 (clk),
        .resetn              (resetn),
        .vga_draw_enable_bus (en),
        .vga_x_out_bus       (x),
        .vga_y_out_bus       (y),
        .vga_RGB_out_bus     (rgb),
        .clear               (clear),
        .clear_colour        (clear_colour),
        .fb_ready            (fb_ready),
        .fb_write            (fb_write),
        .fb_address          (fb_address),
        .fb_colour           (fb_colour),
        .busy                (busy),
        .overflow            (overflow),
        .clear_done          (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; en = 1'b0; x = 8'd0; y = 8'd0; rgb = 24'd0;
        clear = 1'b0; clear_colour = 9'd0; fb_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({fb_write, fb_address, fb_colour, busy, overflow, clear_done} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {fb_write, fb_address, fb_colour, busy, overflow, clear_done});
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (fb_write !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got write=%0b busy=%0b expected 0 0", fb_write, busy);
        end
    endtask

    task automatic test_single_pixel();
        fb_ready = 1'b1;
        en = 1'b1; x = 8'd3; y = 8'd2; rgb = 24'hFF0080;
        tick();
        en = 1'b0;
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd323 || fb_colour !== 9'b111000100) begin
            failures++;
            $display("FAIL single_write: got w=%0b a=%0d c=%0h expected 1 323 1c4",
                     fb_write, fb_address, fb_colour);
        end
        tick();
        checks++;
        if (fb_write !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got w=%0b busy=%0b expected 0 0", fb_write, busy);
        end
    endtask

    task automatic test_clipping();
        fb_ready = 1'b1;
        en = 1'b1; x = 8'd160; y = 8'd5; rgb = 24'hFFFFFF;
        tick();
        x = 8'd0; y = 8'd120;
        checks++;
        if (fb_write !== 1'b0) begin
            failures++;
            $display("FAIL clip_x: got write=%0b expected 0", fb_write);
        end
        tick();
        en = 1'b0;
        checks++;
        if (fb_write !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clip_y: got w=%0b ovf=%0b busy=%0b expected 0 0 0", fb_write, overflow, busy);
        end
        en = 1'b1; x = 8'd159; y = 8'd119; rgb = 24'h20E0A0;
        tick();
        en = 1'b0;
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd19199 || fb_colour !== 9'h07D) begin
            failures++;
            $display("FAIL clip_corner: got w=%0b a=%0d c=%0h expected 1 19199 7d",
                     fb_write, fb_address, fb_colour);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        fb_ready = 1'b1;
        en = 1'b1; x = 8'd0; y = 8'd0; rgb = 24'hFFFFFF;
        tick();
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd0 || fb_colour !== 9'h1FF) begin
            failures++;
            $display("FAIL b2b_0: got w=%0b a=%0d c=%0h expected 1 0 1ff", fb_write, fb_address, fb_colour);
        end
        x = 8'd1; rgb = 24'h000000;
        tick();
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd1 || fb_colour !== 9'h000) begin
            failures++;
            $display("FAIL b2b_1: got w=%0b a=%0d c=%0h expected 1 1 0", fb_write, fb_address, fb_colour);
        end
        x = 8'd159; rgb = 24'h204060;
        tick();
        en = 1'b0;
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd159 || fb_colour !== 9'h053) begin
            failures++;
            $display("FAIL b2b_2: got w=%0b a=%0d c=%0h expected 1 159 53", fb_write, fb_address, fb_colour);
        end
        tick();
        checks++;
        if (fb_write !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got write=%0b expected 0", fb_write);
        end
    endtask

    task automatic test_full_push_pop();
        fb_ready = 1'b0;
        y = 8'd0;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; x = 8'(20 + i); rgb = rgb_tab[i];
            tick();
        end
        en = 1'b1; x = 8'd24; rgb = rgb_tab[4]; fb_ready = 1'b1;
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd20) begin
            failures++;
            $display("FAIL fpp_head: got w=%0b a=%0d expected 1 20", fb_write, fb_address);
        end
        tick();
        en = 1'b0;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (fb_write !== 1'b1 || fb_address !== 15'(20 + i) || fb_colour !== col_tab[i]) begin
                failures++;
                $display("FAIL fpp_entry%0d: got w=%0b a=%0d c=%0h expected 1 %0d %0h",
                         i, fb_write, fb_address, fb_colour, 20 + i, col_tab[i]);
            end
            tick();
        end
        checks++;
        if (fb_write !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fpp_end: got w=%0b ovf=%0b expected 0 0", fb_write, overflow);
        end
    endtask

    task automatic test_backpressure();
        fb_ready = 1'b0;
        y = 8'd1;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; x = 8'(i); rgb = rgb_tab[i];
            tick();
            if (i == 1) begin
                checks++;
                if (fb_write !== 1'b1 || fb_address !== 15'd160 || fb_colour !== 9'h000) begin
                    failures++;
                    $display("FAIL bp_hold: got w=%0b a=%0d c=%0h expected 1 160 0",
                             fb_write, fb_address, fb_colour);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || fb_address !== 15'd160) begin
            failures++;
            $display("FAIL bp_full: got ovf=%0b busy=%0b a=%0d expected 1 1 160", overflow, busy, fb_address);
        end
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fb_write !== 1'b1 || fb_address !== 15'(160 + i) || fb_colour !== col_tab[i]) begin
                failures++;
                $display("FAIL bp_entry%0d: got w=%0b a=%0d c=%0h expected 1 %0d %0h",
                         i, fb_write, fb_address, fb_colour, 160 + i, col_tab[i]);
            end
            tick();
        end
        checks++;
        if (fb_write !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_end: got w=%0b ovf=%0b expected 0 1", fb_write, overflow);
        end
    endtask

    task automatic test_clear();
        int exp_addr;
        int cyc;
        int bad;
        int bad_addr;
        fb_ready = 1'b1;
        clear = 1'b1; clear_colour = 9'h1FF;
        tick();
        clear = 1'b0;
        checks++;
        if (busy !== 1'b1 || fb_write !== 1'b0) begin
            failures++;
            $display("FAIL clr_pending: got busy=%0b w=%0b expected 1 0", busy, fb_write);
        end
        tick();
        clear_colour = 9'h000;
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_entry: got ovf=%0b busy=%0b expected 0 1", overflow, busy);
        end
        exp_addr = 0; cyc = 0; bad = 0; bad_addr = 0;
        x = 8'd10; y = 8'd10; rgb = 24'hFF0080;
        while (exp_addr < 19200 && cyc < 20000) begin
            en       = (cyc == 100);
            clear    = (cyc == 200);
            fb_ready = !(cyc >= 300 && cyc < 303);
            if (fb_write !== 1'b1 || fb_address !== 15'(exp_addr) ||
                fb_colour !== 9'h1FF || clear_done !== 1'b0) begin
                if (bad == 0) bad_addr = exp_addr;
                bad++;
            end
            if (fb_ready) exp_addr++;
            tick();
            cyc++;
        end
        en = 1'b0; clear = 1'b0; fb_ready = 1'b1;
        checks++;
        if (exp_addr != 19200) begin
            failures++;
            $display("FAIL clr_timeout: got %0d writes expected 19200", exp_addr);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clr_sequence: got %0d bad cycles first at addr %0d expected 0", bad, bad_addr);
        end
        checks++;
        if (clear_done !== 1'b1 || fb_write !== 1'b0) begin
            failures++;
            $display("FAIL clr_done: got done=%0b w=%0b expected 1 0", clear_done, fb_write);
        end
        tick();
        checks++;
        if (clear_done !== 1'b0 || fb_write !== 1'b1 || fb_address !== 15'd1610 || fb_colour !== 9'h1C4) begin
            failures++;
            $display("FAIL clr_pixel: got done=%0b w=%0b a=%0d c=%0h expected 0 1 1610 1c4",
                     clear_done, fb_write, fb_address, fb_colour);
        end
        tick();
        checks++;
        if (fb_write !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_after: got w=%0b busy=%0b expected 0 0", fb_write, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int bad;
        fb_ready = 1'b1;
        clear = 1'b1; clear_colour = 9'h0A5;
        tick();
        clear = 1'b0;
        n = 0;
        while (fb_address !== 15'd500 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (fb_address !== 15'd500 || fb_write !== 1'b1 || fb_colour !== 9'h0A5) begin
            failures++;
            $display("FAIL rst_reach500: got a=%0d w=%0b c=%0h expected 500 1 a5",
                     fb_address, fb_write, fb_colour);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({fb_write, fb_address, fb_colour, busy, overflow, clear_done} !== 29'd0) begin
            failures++;
            $display("FAIL rst_async: got %0h expected 0",
                     {fb_write, fb_address, fb_colour, busy, overflow, clear_done});
        end
        tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fb_write !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_pixel();
        test_clipping();
        test_back_to_back();
        test_full_push_pop();
        test_backpressure();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
